// File: rtl/selftest_status_monitor.sv
// On-FPGA self-test monitor: tracks NUM_CH channels against a run watchdog and
// drives the board pass/fail GPIO plus a status LED.
module selftest_status_monitor #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned WATCHDOG = 100000,
  parameter int unsigned CNT_W    = 17,
  parameter int unsigned HB_BIT   = 24
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_done,
  input  logic [NUM_CH-1:0] ch_ok,
  output logic              busy,
  output logic              gpio_out_pass,
  output logic              gpio_out_fail,
  output logic              timeout,
  output logic [NUM_CH-1:0] done_mask,
  output logic [NUM_CH-1:0] fail_mask,
  output logic [CNT_W-1:0]  elapsed,
  output logic              led
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PASS,
    S_FAIL
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(WATCHDOG - 1);

  state_t            state;
  logic [HB_BIT:0]   hb_cnt;
  logic [NUM_CH-1:0] new_done;
  logic [NUM_CH-1:0] done_nxt;
  logic [NUM_CH-1:0] fail_nxt;

  // Only the first completion per channel per run is recorded.
  always_comb begin
    new_done = '0;
    done_nxt = '0;
    fail_nxt = '0;
    new_done = ch_done & ~done_mask;
    done_nxt = done_mask | new_done;
    fail_nxt = fail_mask | (new_done & ~ch_ok);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      hb_cnt    <= '0;
      done_mask <= '0;
      fail_mask <= '0;
      elapsed   <= '0;
      timeout   <= 1'b0;
    end else begin
      hb_cnt <= hb_cnt + 1'b1;
      case (state)
        S_RUN: begin
          elapsed   <= elapsed + 1'b1;
          done_mask <= done_nxt;
          fail_mask <= fail_nxt;
          // Exit priority: any failure, then all done, then watchdog expiry.
          if (|fail_nxt) begin
            state <= S_FAIL;
          end else if (&done_nxt) begin
            state <= S_PASS;
          end else if (elapsed == WD_LAST) begin
            state   <= S_FAIL;
            timeout <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state     <= S_RUN;
            done_mask <= '0;
            fail_mask <= '0;
            elapsed   <= '0;
            timeout   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy          = (state == S_RUN);
  assign gpio_out_pass = (state == S_PASS);
  assign gpio_out_fail = (state == S_FAIL);

  always_comb begin
    led = 1'b0;
    case (state)
      S_RUN:   led = hb_cnt[HB_BIT];
      S_PASS:  led = 1'b1;
      S_FAIL:  led = hb_cnt[HB_BIT-2];
      default: led = 1'b0;
    endcase
  end

endmodule
